// File: rtl/sobol_seq_gen.sv
// Gray-code Sobol point generator: (index n, dimension d) -> WIDTH-bit fraction x(n,d).
// Latency 2 cycles (S1: gray code + row base, S2: XOR of selected direction numbers), 1 point/cycle.
// Backpressure: ready_out = ~v1 | ~v2 | ready_in; a stalled output holds sobol_out/valid_out stable.
module sobol_seq_gen #(
    parameter int    WIDTH     = 32,
    parameter int    M         = 50,
    parameter string INIT_FILE = ""
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    output logic                 ready_out,
    input  logic [WIDTH-1:0]     idx_in,
    input  logic [$clog2(M)-1:0] dim_in,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic [WIDTH-1:0]     sobol_out,
    output logic [WIDTH-1:0]     direction [M*WIDTH]
);
    localparam int AW = $clog2(M * WIDTH);

    // Built-in direction numbers. Dim 0 (and any dim >= 3) is van der Corput;
    // dims 1 and 2 follow their primitive-polynomial recurrences.
    function automatic logic [WIDTH-1:0] dir_default(input int d, input int k);
        logic [WIDTH-1:0] vm2;
        logic [WIDTH-1:0] vm1;
        logic [WIDTH-1:0] vk;
        vm2 = '0;
        vm1 = '0;
        vk  = '0;
        if (d == 1) begin
            vk = {1'b1, {(WIDTH-1){1'b0}}};
            for (int j = 1; j <= k; j++) begin
                vk = vk ^ (vk >> 1);
            end
        end else if (d == 2) begin
            vm2 = {1'b1, {(WIDTH-1){1'b0}}};
            vm1 = {2'b11, {(WIDTH-2){1'b0}}};
            if (k == 0) begin
                vk = vm2;
            end else begin
                vk = vm1;
                for (int j = 2; j <= k; j++) begin
                    vk  = vm1 ^ vm2 ^ (vm2 >> 2);
                    vm2 = vm1;
                    vm1 = vk;
                end
            end
        end else begin
            vk = {1'b1, {(WIDTH-1){1'b0}}} >> k;
        end
        return vk;
    endfunction

    for (genvar d = 0; d < M; d++) begin : g_dim
        for (genvar k = 0; k < WIDTH; k++) begin : g_bit
            assign direction[d*WIDTH+k] = dir_default(d, k);
        end
    end

    logic             v1;
    logic             v2;
    logic             en1;
    logic             en2;
    logic             oor1;
    logic [WIDTH-1:0] g1;
    logic [AW-1:0]    b1;
    logic [WIDTH-1:0] xor_s1;

    assign en2       = ~v2 | ready_in;
    assign en1       = ~v1 | en2;
    assign ready_out = en1;
    assign valid_out = v2;

    // S1: register the gray code and the ROM row base of each accepted request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1   <= 1'b0;
            g1   <= '0;
            b1   <= '0;
            oor1 <= 1'b0;
        end else if (en1) begin
            v1 <= valid_in;
            if (valid_in) begin
                g1 <= idx_in ^ (idx_in >> 1);
                if (int'(dim_in) >= M) begin
                    oor1 <= 1'b1;
                    b1   <= '0;
                end else begin
                    oor1 <= 1'b0;
                    b1   <= AW'(int'(dim_in) * WIDTH);
                end
            end
        end
    end

    // XOR together the direction numbers picked by the gray-code bits; out-of-range dims give 0
    always_comb begin
        xor_s1 = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (g1[k]) begin
                xor_s1 = xor_s1 ^ direction[b1 + AW'(k)];
            end
        end
        if (oor1) begin
            xor_s1 = '0;
        end
    end

    // S2: output register; holds while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2        <= 1'b0;
            sobol_out <= '0;
        end else if (en2) begin
            v2 <= v1;
            if (v1) begin
                sobol_out <= xor_s1;
            end
        end
    end
endmodule

// File: tb/tb_sobol_seq_gen.sv
`timescale 1ns/1ps
module tb_sobol_seq_gen;
    localparam int W  = 32;
    localparam int M  = 50;
    localparam int DW = $clog2(M);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid_in = 1'b0;
    logic          ready_in = 1'b1;
    logic          ready_out;
    logic          valid_out;
    logic [W-1:0]  idx_in = '0;
    logic [DW-1:0] dim_in = '0;
    logic [W-1:0]  sobol_out;
    logic [W-1:0]  direction [M*W];

    sobol_seq_gen #(.WIDTH(W), .M(M), .INIT_FILE("")) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .idx_in    (idx_in),
        .dim_in    (dim_in),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .sobol_out (sobol_out),
        .direction (direction)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    int           n_in   = 0;
    int           n_out  = 0;
    bit           last_acc = 1'b0;
    logic [W-1:0] dir_m [M*W];
    logic [W-1:0] exp_q [$];

    typedef struct {
        logic [W-1:0] idx;
        int           dim;
        logic [W-1:0] exp;
    } vec_t;

    // Reference direction table, filled straight from the recurrences.
    task automatic build_model();
        for (int d = 0; d < M; d++) begin
            for (int k = 0; k < W; k++) begin
                logic [W-1:0] v;
                if (d == 1 && k > 0)
                    v = dir_m[d*W+k-1] ^ (dir_m[d*W+k-1] >> 1);
                else if (d == 2 && k == 1)
                    v = 32'hC000_0000;
                else if (d == 2 && k > 1)
                    v = dir_m[d*W+k-1] ^ dir_m[d*W+k-2] ^ (dir_m[d*W+k-2] >> 2);
                else
                    v = 32'h8000_0000 >> k;
                dir_m[d*W+k] = v;
            end
        end
    endtask

    function automatic logic [W-1:0] model(logic [W-1:0] n, int d);
        logic [W-1:0] g = n ^ (n >> 1);
        logic [W-1:0] x = '0;
        if (d >= M) return '0;
        for (int k = 0; k < W; k++)
            if (g[k]) x = x ^ dir_m[d*W+k];
        return x;
    endfunction

    task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Inputs are set just after a negedge; record the handshakes that the next
    // posedge will perform, then advance to the following negedge.
    task automatic tick();
        #1;
        last_acc = valid_in && ready_out;
        if (last_acc) begin
            exp_q.push_back(model(idx_in, int'(dim_in)));
            n_in++;
        end
        if (valid_out && ready_in) begin
            n_out++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_output actual=%h expected=none", sobol_out);
            end else begin
                check("stream_data", sobol_out, exp_q.pop_front());
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_vec(int i, logic [W-1:0] n, int d, logic [W-1:0] e);
        valid_in = 1'b1;
        idx_in   = n;
        dim_in   = DW'(d);
        ready_in = 1'b1;
        #1 check($sformatf("vec%0d_ready", i), ready_out, 1);
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        check($sformatf("vec%0d_not_yet_valid", i), valid_out, 0);
        @(posedge clk);
        @(negedge clk);
        check($sformatf("vec%0d_valid", i), valid_out, 1);
        check($sformatf("vec%0d_data", i), sobol_out, e);
        @(posedge clk);
        @(negedge clk);
        check($sformatf("vec%0d_drained", i), valid_out, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs [12];
        logic [W-1:0] exp0;
        int           base_in;
        int           base_out;
        int           sent;
        int           bad;

        build_model();
        vecs[0]  = '{32'h0000_0000, 0,  32'h0000_0000};
        vecs[1]  = '{32'h0000_0001, 0,  32'h8000_0000};
        vecs[2]  = '{32'h0000_0002, 1,  32'h4000_0000};
        vecs[3]  = '{32'h0000_0003, 0,  32'h4000_0000};
        vecs[4]  = '{32'h0000_0004, 2,  32'hA000_0000};
        vecs[5]  = '{32'hFFFF_FFFF, 0,  32'h0000_0001};
        vecs[6]  = '{32'h0000_0005, 3,  32'hE000_0000};
        vecs[7]  = '{32'h0000_0005, 49, 32'hE000_0000};
        vecs[8]  = '{32'hFFFF_FFFF, 1,  32'hFFFF_FFFF};
        vecs[9]  = '{32'h0000_0007, 55, 32'h0000_0000};
        vecs[10] = '{32'h0000_0006, 1,  32'h2000_0000};
        vecs[11] = '{32'h0000_0008, 0,  32'h3000_0000};

        // Reset state and ROM contents
        @(negedge clk);
        check("rst_valid_out", valid_out, 0);
        check("rst_sobol_out", sobol_out, 0);
        check("rst_ready_out", ready_out, 1);
        check("rst_dir0", direction[0], 32'h8000_0000);
        check("rst_dir1", direction[1], 32'h4000_0000);
        check("rst_dir2", direction[2], 32'h2000_0000);
        for (int d = 0; d < M; d++) begin
            bad = 0;
            for (int k = 0; k < W; k++)
                if (direction[d*W+k] !== dir_m[d*W+k]) bad++;
            check($sformatf("rom_dim%0d_mismatches", d), bad, 0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Golden vectors
        for (int i = 0; i < 12; i++)
            run_vec(i, vecs[i].idx, vecs[i].dim, vecs[i].exp);

        // Stall: output held while S1 fills, then in-order drain
        base_in  = n_in;
        base_out = n_out;
        ready_in = 1'b1;
        valid_in = 1'b1;
        idx_in   = 32'h0000_000B;
        dim_in   = DW'(1);
        exp0     = model(32'h0000_000B, 1);
        tick();
        ready_in = 1'b0;
        idx_in   = 32'h1234_5678;
        dim_in   = DW'(2);
        #1 check("stall_ready_while_s1_free", ready_out, 1);
        tick();
        idx_in = 32'hDEAD_BEEF;
        dim_in = DW'(7);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall_ready_low", ready_out, 0);
            check("stall_valid_held", valid_out, 1);
            check("stall_data_held", sobol_out, exp0);
            tick();
        end
        ready_in = 1'b1;
        #1 check("stall_release_ready", ready_out, 1);
        tick();
        valid_in = 1'b0;
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) tick();
        check("stall_in_count", n_in - base_in, 3);
        check("stall_out_count", n_out - base_out, 3);
        check("stall_queue_empty", exp_q.size(), 0);

        // Ten back-to-back requests
        base_out = n_out;
        for (int i = 0; i < 10; i++) begin
            valid_in = 1'b1;
            ready_in = 1'b1;
            idx_in   = $urandom;
            dim_in   = DW'($urandom_range(0, M-1));
            #1 check("burst_ready", ready_out, 1);
            tick();
            if (i == 1) check("burst_latency_no_output", n_out - base_out, 0);
            if (i == 9) check("burst_rate_after10", n_out - base_out, 8);
        end
        valid_in = 1'b0;
        tick();
        tick();
        check("burst_out_count", n_out - base_out, 10);
        check("burst_queue_empty", exp_q.size(), 0);

        // Random valid/ready toggling, 1000 points
        base_in  = n_in;
        base_out = n_out;
        sent     = 0;
        last_acc = 1'b1;
        valid_in = 1'b0;
        for (int c = 0; c < 20000 && (n_out - base_out) < 1000; c++) begin
            if (!valid_in || last_acc) begin
                if (sent < 1000 && $urandom_range(0, 3) != 0) begin
                    valid_in = 1'b1;
                    sent++;
                    case ($urandom_range(0, 7))
                        0:       idx_in = '0;
                        1:       idx_in = '1;
                        default: idx_in = $urandom;
                    endcase
                    dim_in = DW'($urandom_range(0, (1 << DW) - 1));
                end else begin
                    valid_in = 1'b0;
                end
            end
            ready_in = ($urandom_range(0, 3) != 0);
            tick();
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        check("random_in_count", n_in - base_in, 1000);
        check("random_out_count", n_out - base_out, 1000);
        check("random_queue_empty", exp_q.size(), 0);

        // Reset with two points in flight
        ready_in = 1'b1;
        valid_in = 1'b1;
        idx_in   = 32'h3;
        dim_in   = DW'(0);
        tick();
        idx_in = 32'h4;
        dim_in = DW'(2);
        tick();
        valid_in = 1'b0;
        check("pre_rst_valid_out", valid_out, 1);
        rst = 1'b1;
        #1;
        check("midrst_valid_out", valid_out, 0);
        check("midrst_sobol_out", sobol_out, 0);
        check("midrst_ready_out", ready_out, 1);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_vec(100, 32'h3, 0, 32'h4000_0000);
        run_vec(101, 32'h4, 2, 32'hA000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
